// File: rtl/store_buffer.sv
// store_buffer: formats RISC-V SB/SH/SW stores into lane-placed words
// and queues them toward data memory over a req/ack handshake.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_funct3,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        misalign,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wptr, rptr;
    logic [AW-1:0] widx, ridx;
    logic [29:0]   q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [3:0]    q_be   [DEPTH];

    logic        full, accept, legal, push, pop, mis_q;
    logic [1:0]  lane;
    logic [3:0]  f_be;
    logic [31:0] f_data;

    assign lane = st_addr[1:0];

    always_comb begin
        legal  = 1'b0;
        f_be   = 4'b0000;
        f_data = st_data;
        unique case (st_funct3)
            3'b000: begin
                legal  = 1'b1;
                f_be   = 4'b0001 << lane;
                f_data = {4{st_data[7:0]}};
            end
            3'b001: begin
                legal  = !lane[0];
                f_be   = 4'b0011 << lane;
                f_data = {2{st_data[15:0]}};
            end
            3'b010: begin
                legal  = (lane == 2'b00);
                f_be   = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    assign widx  = wptr[AW-1:0];
    assign ridx  = rptr[AW-1:0];
    assign full  = (wptr[AW] != rptr[AW]) && (widx == ridx);
    assign empty = (wptr == rptr);

    // Ready depends only on registered pointers: no same-cycle bypass.
    assign st_ready = !full;
    assign accept   = st_valid & st_ready;
    assign push     = accept & legal;
    assign mem_req  = !empty;
    assign pop      = mem_req & mem_ack;

    assign mem_addr  = {q_addr[ridx], 2'b00};
    assign mem_wdata = q_data[ridx];
    assign mem_be    = empty ? 4'b0000 : q_be[ridx];
    assign misalign  = mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            mis_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
                q_be[i]   <= '0;
            end
        end else begin
            if (push) begin
                q_addr[widx] <= st_addr[31:2];
                q_data[widx] <= f_data;
                q_be[widx]   <= f_be;
                wptr         <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            mis_q <= accept & !legal;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed plus randomized stimulus against a
// queue-based reference model of the store buffer.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [2:0]  st_funct3 = '0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign;
    logic        empty;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .misalign(misalign), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of formatted writes plus the drop flag.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } ent_t;

    ent_t mq[$];
    bit   mmis = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mmis = 0;
        end else begin
            bit   acc;
            bit   ok;
            int   ln;
            ent_t e;
            acc    = st_valid && (mq.size() < DEPTH);
            ln     = int'(st_addr % 32'd4);
            ok     = 0;
            e.addr = st_addr & ~32'h3;
            e.wd   = st_data;
            e.be   = 4'b0000;
            case (st_funct3)
                3'd0: begin
                    ok   = 1;
                    e.be = 4'b0001 << ln;
                    e.wd = st_data[7:0] * 32'h0101_0101;
                end
                3'd1: begin
                    ok   = (ln % 2 == 0);
                    e.be = 4'b0011 << ln;
                    e.wd = st_data[15:0] * 32'h0001_0001;
                end
                3'd2: begin
                    ok   = (ln == 0);
                    e.be = 4'b1111;
                end
                default: ok = 0;
            endcase
            if (mq.size() > 0 && mem_ack) void'(mq.pop_front());
            if (acc && ok) mq.push_back(e);
            mmis = acc && !ok;
        end
    end

    always @(negedge clk) begin
        int n;
        n = mq.size();
        check("st_ready", 32'(st_ready), 32'(n < DEPTH));
        check("empty", 32'(empty), 32'(n == 0));
        check("mem_req", 32'(mem_req), 32'(n != 0));
        check("misalign", 32'(misalign), 32'(mmis));
        if (n != 0) begin
            check("mem_be", 32'(mem_be), 32'(mq[0].be));
            check("mem_addr", mem_addr, mq[0].addr);
            check("mem_wdata", mem_wdata, mq[0].wd);
        end else begin
            check("mem_be_idle", 32'(mem_be), 32'h0);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f);
        bit r;
        st_valid  = 1'b1;
        st_addr   = a;
        st_data   = d;
        st_funct3 = f;
        r = 0;
        for (int k = 0; k < 100 && !r; k++) begin
            r = st_ready;
            @(negedge clk);
        end
        check("send_accept", 32'(r), 32'h1);
        st_valid = 1'b0;
    endtask

    logic [3:0] sb_be [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(st_ready), 32'h1);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_be", 32'(mem_be), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_mis", 32'(misalign), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // SB sweep with memory always acknowledging
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h100 + 32'(i), 32'h0000_00A5, 3'b000);
            check("sb_be", 32'(mem_be), 32'(sb_be[i]));
            check("sb_addr", mem_addr, 32'h100);
            check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        end
        @(negedge clk);

        send(32'h202, 32'h0000_1234, 3'b001);
        check("sh_addr", mem_addr, 32'h200);
        check("sh_be", 32'(mem_be), 32'hC);
        check("sh_wdata", mem_wdata, 32'h1234_1234);
        send(32'h300, 32'hDEAD_BEEF, 3'b010);
        check("sw_be", 32'(mem_be), 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // Three back-to-back illegal requests
        st_valid = 1'b1; st_addr = 32'h301; st_funct3 = 3'b010;
        @(negedge clk);
        st_addr = 32'h203; st_funct3 = 3'b001;
        check("mis1", 32'(misalign), 32'h1);
        check("mis1_empty", 32'(empty), 32'h1);
        @(negedge clk);
        st_addr = 32'h0; st_funct3 = 3'b011;
        check("mis2", 32'(misalign), 32'h1);
        @(negedge clk);
        st_valid = 1'b0;
        check("mis3", 32'(misalign), 32'h1);
        check("mis3_ready", 32'(st_ready), 32'h1);
        @(negedge clk);
        check("mis_off", 32'(misalign), 32'h0);
        check("mis_empty", 32'(empty), 32'h1);

        // Fill with memory stalled, then release one entry
        mem_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            send(32'h400 + 32'(4 * i), 32'(i), 3'b010);
        st_valid = 1'b1; st_addr = 32'h410; st_data = 32'h99; st_funct3 = 3'b010;
        check("full_ready", 32'(st_ready), 32'h0);
        repeat (2) @(negedge clk);
        check("full_hold", 32'(st_ready), 32'h0);
        check("full_head", mem_addr, 32'h400);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("pop_ready", 32'(st_ready), 32'h1);
        check("pop_head", mem_addr, 32'h404);
        @(negedge clk);
        st_valid = 1'b0;
        check("refill_ready", 32'(st_ready), 32'h0);
        mem_ack = 1'b1;
        repeat (6) @(negedge clk);
        check("fill_drained", 32'(empty), 32'h1);

        // Sustained push/pop at count 2 across pointer wrap
        mem_ack = 1'b0;
        send(32'h500, 32'h5000, 3'b010);
        send(32'h504, 32'h5004, 3'b010);
        mem_ack = 1'b1;
        for (int i = 2; i < 16; i++)
            send(32'h500 + 32'(4 * i), 32'h5000 + 32'(4 * i), 3'b010);
        check("stream_head", mem_addr, 32'h538);
        repeat (3) @(negedge clk);
        check("stream_empty", 32'(empty), 32'h1);

        // Asynchronous reset with three queued entries
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++)
            send(32'h700 + 32'(4 * i), 32'(i), 3'b010);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 32'(mem_req), 32'h0);
        check("arst_be", 32'(mem_be), 32'h0);
        check("arst_mis", 32'(misalign), 32'h0);
        check("arst_empty", 32'(empty), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h601, 32'h0000_005A, 3'b000);
        check("post_req", 32'(mem_req), 32'h1);
        check("post_be", 32'(mem_be), 32'h2);
        check("post_wdata", mem_wdata, 32'h5A5A_5A5A);
        mem_ack = 1'b1;
        @(negedge clk);

        // Randomized traffic with varying memory stall rates
        for (int blk = 0; blk < 8; blk++) begin
            int ackpct;
            ackpct = 20 + 10 * blk;
            for (int c = 0; c < 100; c++) begin
                st_valid  = ($urandom % 4) != 0;
                st_addr   = $urandom;
                st_data   = $urandom;
                st_funct3 = (($urandom % 8) < 6) ? 3'($urandom % 3) : 3'($urandom);
                mem_ack   = int'($urandom % 100) < ackpct;
                @(negedge clk);
            end
        end
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        repeat (8) @(negedge clk);
        check("final_empty", 32'(empty), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Store-path buffer between the store-data formatting stage and the data-memory bus. It accepts store requests from the execute/memory stage: byte address, 32-bit store data and RISC-V store funct3. For each request it computes word-aligned address, lane-placed write data and byte enables, then queues the result in a small FIFO. It drains the FIFO to data memory over a req/ack handshake so that multi-cycle memory writes do not stall the pipeline until the buffer fills.

## Interface
- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low
- st_valid  in  1  store request present
- st_ready  out  1  buffer can accept a request this cycle
- st_addr  in  32  byte address of store
- st_data  in  32  store data; low byte/halfword significant for SB/SH
- st_funct3  in  3  000 SB, 001 SH, 010 SW; other codes illegal
- mem_req  out  1  head entry valid toward memory
- mem_ack  in  1  memory has taken the head entry this cycle
- mem_addr  out  32  {head addr[31:2], 2'b00}
- mem_wdata  out  32  lane-placed write data
- mem_be  out  4  byte enables, bit i = byte lane i (bits [8i+7:8i])
- misalign  out  1  one-cycle pulse: last accepted request was dropped
- empty  out  1  FIFO holds no entries

## Operation
- Accept = st_valid & st_ready. st_ready = !full, registered-state derived; no dependence on mem_ack (no full-bypass).
- Formatting on accept, with a = st_addr[1:0]:
  - SB: be = 4'b0001 << a; wdata = {4{st_data[7:0]}}.
  - SH: legal only if a[0]==0; be = 4'b0011 << a; wdata = {2{st_data[15:0]}}.
  - SW: legal only if a==0; be = 4'b1111; wdata = st_data.
- An illegal accepted request is not enqueued. It is a misaligned SH/SW or a funct3 other than 000/001/010. It is still consumed (handshake completes), and misalign is 1 in the following cycle only.
- FIFO: write/read pointers of log2(DEPTH)+1 bits. full = MSBs differ & low bits equal; empty = pointers equal. Pointers wrap modulo 2·DEPTH.
- Drain: mem_req = !empty. mem_addr/mem_wdata/mem_be are driven from the head entry and held stable while mem_req & !mem_ack. Pop on mem_req & mem_ack.
- mem_ack while mem_req=0 is ignored.
- Simultaneous push and pop (not full, not empty): both occur; count unchanged; order preserved strictly FIFO.
- Push while empty: entry appears on mem_* the next cycle; it is never combinationally forwarded.

## Timing
- Reset (rst_n low, asynchronous): pointers 0, empty=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign=0, st_ready=1. Buffered stores are discarded; reset mid-handshake abandons the head entry.
- Latency: accept at edge N, so mem_req=1 with that entry from after edge N (cycle N+1) when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- st_ready deasserts the cycle after the DEPTH-th outstanding entry is written. It reasserts the cycle after the first pop from full.
- misalign is registered: high exactly one cycle after the dropping accept edge. Back-to-back illegal requests keep it high on consecutive cycles.
- mem_be=0 whenever mem_req=0. Other mem_* outputs when empty hold the last head value (don't-care for verification).

## Test plan
- SB sweep: addr 0x100..0x103, data 0x000000A5, mem_ack tied 1 -> four writes at 0x100 with be 0001/0010/0100/1000, wdata 0xA5A5A5A5 each, in order.
- SH/SW legal: SH 0x202 data 0x1234 -> addr 0x200, be 1100, wdata 0x12341234. SW 0x300 data 0xDEADBEEF -> be 1111, wdata 0xDEADBEEF.
- Misalign: SW 0x301, then SH 0x203, then funct3=011 -> nothing enqueued, empty stays 1, misalign high for three consecutive cycles, st_ready stays 1.
- Fill/backpressure: mem_ack=0, push DEPTH+1 requests -> st_ready=0 after DEPTH; the (DEPTH+1)th is held on st_*. With one ack: head pops, st_ready=1 next cycle, and the held request is accepted. Drain order matches issue order.
- Simultaneous push/pop at count 2 with mem_ack=1 -> count stays 2, mem_* outputs stable until ack, no entry lost or duplicated. Run across pointer wrap (≥3·DEPTH stores).
- Reset mid-operation: 3 entries queued, mem_req=1, drop rst_n asynchronously between edges -> mem_req, mem_be and misalign go 0 immediately, empty=1. After release the next store appears on mem_* one cycle after accept.
